// File: rtl/blink_scheduler.sv
// blink_scheduler
//   Programmable LED sequence controller. A 4-entry table of
//   (pattern, duration) steps is loaded over a valid/ready port while idle.
//   On start, the four steps are played in order on leds, once or looping.
//   Each step lasts max(dur,1) ticks, and one tick is TICK_CYCLES clocks.
//
// Ports
//   clk, rst     : system clock, asynchronous active-high reset
//   cfg_valid    : table write request
//   cfg_ready    : write accepted when high together with cfg_valid (IDLE only)
//   cfg_addr     : table entry index 0..3
//   cfg_pattern  : LED pattern for the entry
//   cfg_dur      : entry duration in ticks (0 behaves as 1)
//   start, stop  : level-sampled playback controls
//   loop         : repeat mode, captured when start is accepted
//   leds         : registered LED drive
//   busy         : high while playing
//   step         : index of the entry on display, 0 when idle
//   done         : one-cycle pulse when a one-shot sequence completes
module blink_scheduler #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_HZ  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [1:0]  cfg_addr,
  input  logic [7:0]  cfg_pattern,
  input  logic [15:0] cfg_dur,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  output logic [7:0]  leds,
  output logic        busy,
  output logic [1:0]  step,
  output logic        done
);

  localparam int          TICK_CYCLES = CLK_FREQ / TICK_HZ;
  localparam logic [31:0] TICK_LAST   = 32'(TICK_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_reg;
  logic [7:0]   leds_reg;
  logic         busy_reg;
  logic [1:0]   step_reg;
  logic         done_reg;
  logic         loop_reg;
  logic [31:0]  presc_reg;
  logic [15:0]  tick_cnt_reg;

  // Table is kept in flops (not RAM) because reset must clear it.
  logic [3:0][7:0]  pattern_tbl;
  logic [3:0][15:0] dur_tbl;

  logic cfg_write;

  // A pending start or stop blocks writes so the table cannot change under
  // the edge that loads pattern[0].
  assign cfg_ready = (state_reg == IDLE) && !start && !stop;
  assign cfg_write = cfg_valid && cfg_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_entry
      logic [7:0]  pattern_reg;
      logic [15:0] dur_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pattern_reg <= '0;
          dur_reg     <= '0;
        end else if (cfg_write && (cfg_addr == 2'(gi))) begin
          pattern_reg <= cfg_pattern;
          dur_reg     <= cfg_dur;
        end
      end

      assign pattern_tbl[gi] = pattern_reg;
      assign dur_tbl[gi]     = dur_reg;
    end
  endgenerate

  // Current step length in ticks, with zero promoted to one.
  logic [15:0] cur_dur;
  logic [15:0] dur_eff;
  logic        tick;
  logic        step_end;

  assign cur_dur  = dur_tbl[step_reg];
  assign dur_eff  = (cur_dur == 16'd0) ? 16'd1 : cur_dur;
  assign tick     = (presc_reg == TICK_LAST);
  // The step ends on the edge where the tick counter would reach dur_eff.
  assign step_end = tick && (({1'b0, tick_cnt_reg} + 17'd1) >= {1'b0, dur_eff});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      leds_reg     <= '0;
      busy_reg     <= 1'b0;
      step_reg     <= '0;
      done_reg     <= 1'b0;
      loop_reg     <= 1'b0;
      presc_reg    <= '0;
      tick_cnt_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          leds_reg <= '0;
          busy_reg <= 1'b0;
          step_reg <= '0;
          if (start && !stop) begin
            state_reg    <= RUN;
            busy_reg     <= 1'b1;
            leds_reg     <= pattern_tbl[0];
            loop_reg     <= loop;
            presc_reg    <= '0;
            tick_cnt_reg <= '0;
          end
        end

        RUN: begin
          if (stop) begin
            // Abort wins over a simultaneous step end.
            state_reg <= IDLE;
            leds_reg  <= '0;
            busy_reg  <= 1'b0;
            step_reg  <= '0;
          end else if (step_end) begin
            presc_reg    <= '0;
            tick_cnt_reg <= '0;
            if (step_reg != 2'd3) begin
              step_reg <= step_reg + 2'd1;
              leds_reg <= pattern_tbl[step_reg + 2'd1];
            end else if (loop_reg) begin
              step_reg <= '0;
              leds_reg <= pattern_tbl[0];
            end else begin
              state_reg <= IDLE;
              leds_reg  <= '0;
              busy_reg  <= 1'b0;
              step_reg  <= '0;
              done_reg  <= 1'b1;
            end
          end else if (tick) begin
            presc_reg    <= '0;
            tick_cnt_reg <= tick_cnt_reg + 16'd1;
          end else begin
            presc_reg <= presc_reg + 32'd1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign leds = leds_reg;
  assign busy = busy_reg;
  assign step = step_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_blink_scheduler.sv
// tb_blink_scheduler
//   Directed bench for blink_scheduler with TICK_CYCLES = 10. A vector table
//   covers configuration writes and IDLE collisions; hand-written sequences
//   cover one-shot playback, loop mode, stop on a step end and async reset.
module tb_blink_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_addr = 2'd0;
  logic [7:0]  cfg_pattern = 8'd0;
  logic [15:0] cfg_dur = 16'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [7:0]  leds;
  logic        busy;
  logic [1:0]  step;
  logic        done;

  always #5 clk = ~clk;

  blink_scheduler #(
    .CLK_FREQ(10_000),
    .TICK_HZ (1000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_pattern(cfg_pattern),
    .cfg_dur    (cfg_dur),
    .start      (start),
    .stop       (stop),
    .loop       (loop),
    .leds       (leds),
    .busy       (busy),
    .step       (step),
    .done       (done)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        cv;
    logic [1:0]  ca;
    logic [7:0]  cp;
    logic [15:0] cd;
    logic        st;
    logic        sp;
    logic        lp;
    logic        e_ready;
    logic [7:0]  e_leds;
    logic        e_busy;
    logic [1:0]  e_step;
    logic        e_done;
    string       name;
  } vec_t;

  vec_t vecs[6];

  // Expected playback: pattern and length in cycles for each entry.
  logic [7:0] m_pat[4];
  int         m_len[4];

  // Checks every cycle of one full pass through the 4 entries, starting in
  // the first cycle after the edge that entered the first step. Returns
  // after the edge that ends the last step.
  task automatic play_seq(input bit poke_cfg);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < m_len[k]; c++) begin
        if (poke_cfg && k == 0) begin
          cfg_valid   = 1'b1;
          cfg_addr    = 2'd2;
          cfg_pattern = 8'hEE;
          cfg_dur     = 16'd7;
          #1;
          chk("run_cfg_ready", 32'(cfg_ready), 32'd0);
        end else begin
          cfg_valid = 1'b0;
        end
        chk("run_leds", 32'(leds), 32'(m_pat[k]));
        chk("run_step", 32'(step), k);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_done", 32'(done), 32'd0);
        clk_step();
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    //           cv    ca    cp     cd      st    sp    lp    rdy   leds   busy  step  done
    vecs[0] = '{1'b1, 2'd0, 8'h81, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, "cfg_w0"};
    vecs[1] = '{1'b1, 2'd1, 8'h42, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, "cfg_w1"};
    vecs[2] = '{1'b1, 2'd2, 8'h24, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, "cfg_w2"};
    vecs[3] = '{1'b1, 2'd3, 8'h18, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0, "cfg_w3"};
    vecs[4] = '{1'b1, 2'd0, 8'hFF, 16'd5, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, "start_stop_idle"};
    vecs[5] = '{1'b1, 2'd0, 8'hFF, 16'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 1'b1, 2'd0, 1'b0, "start_cfg_nowrite"};

    // Power-on reset.
    #1 rst = 1'b1;
    #1;
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);

    // Configuration writes and IDLE collisions.
    for (int i = 0; i < 6; i++) begin
      cfg_valid   = vecs[i].cv;
      cfg_addr    = vecs[i].ca;
      cfg_pattern = vecs[i].cp;
      cfg_dur     = vecs[i].cd;
      start       = vecs[i].st;
      stop        = vecs[i].sp;
      loop        = vecs[i].lp;
      #1;
      chk({vecs[i].name, "_ready"}, 32'(cfg_ready), 32'(vecs[i].e_ready));
      clk_step();
      chk({vecs[i].name, "_leds"}, 32'(leds), 32'(vecs[i].e_leds));
      chk({vecs[i].name, "_busy"}, 32'(busy), 32'(vecs[i].e_busy));
      chk({vecs[i].name, "_step"}, 32'(step), 32'(vecs[i].e_step));
      chk({vecs[i].name, "_done"}, 32'(done), 32'(vecs[i].e_done));
    end
    start     = 1'b0;
    stop      = 1'b0;
    loop      = 1'b0;
    cfg_valid = 1'b0;

    // One-shot playback (started by the last vector), with cfg_valid poked
    // during RUN; the later loop pass shows the table stayed intact.
    m_pat[0] = 8'h81; m_len[0] = 20;
    m_pat[1] = 8'h42; m_len[1] = 10;
    m_pat[2] = 8'h24; m_len[2] = 30;
    m_pat[3] = 8'h18; m_len[3] = 10;
    play_seq(1'b1);
    chk("oneshot_done", 32'(done), 32'd1);
    chk("oneshot_leds", 32'(leds), 32'd0);
    chk("oneshot_busy", 32'(busy), 32'd0);
    chk("oneshot_step", 32'(step), 32'd0);
    clk_step();
    chk("oneshot_done_pulse", 32'(done), 32'd0);

    // Loop mode; loop drops right after start and must be ignored.
    start = 1'b1;
    loop  = 1'b1;
    clk_step();
    start = 1'b0;
    loop  = 1'b0;
    play_seq(1'b0);
    chk("loop_wrap_leds", 32'(leds), 32'h81);
    chk("loop_wrap_step", 32'(step), 32'd0);
    chk("loop_wrap_busy", 32'(busy), 32'd1);
    chk("loop_wrap_done", 32'(done), 32'd0);
    repeat (19) begin
      clk_step();
      chk("loop_no_done", 32'(done), 32'd0);
    end
    chk("loop_pre_stop_leds", 32'(leds), 32'h81);
    chk("loop_pre_stop_step", 32'(step), 32'd0);
    // Stop lands on the edge where step 0 would end.
    stop = 1'b1;
    clk_step();
    stop = 1'b0;
    chk("stop_leds", 32'(leds), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_step", 32'(step), 32'd0);
    chk("stop_done", 32'(done), 32'd0);
    #1;
    chk("stop_cfg_ready", 32'(cfg_ready), 32'd1);
    clk_step();
    chk("stop_done_after", 32'(done), 32'd0);
    chk("stop_busy_after", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of step 1.
    start = 1'b1;
    clk_step();
    start = 1'b0;
    repeat (25) clk_step();
    chk("pre_rst_leds", 32'(leds), 32'h42);
    chk("pre_rst_step", 32'(step), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_leds", 32'(leds), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_step", 32'(step), 32'd0);
    clk_step();
    rst = 1'b0;
    clk_step();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ready", 32'(cfg_ready), 32'd1);

    // Playback of the cleared table: 4 x 10 cycles of zero, then done.
    for (int k = 0; k < 4; k++) begin
      m_pat[k] = 8'h00;
      m_len[k] = 10;
    end
    start = 1'b1;
    clk_step();
    start = 1'b0;
    play_seq(1'b0);
    chk("cleared_done", 32'(done), 32'd1);
    chk("cleared_busy", 32'(busy), 32'd0);
    clk_step();
    chk("cleared_done_pulse", 32'(done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
